eater_cpu: RTL and testbench

//   Self-contained 8-bit SAP-1-class CPU: 16x8 RAM, 4-bit PC/MAR, A/B regs, add/sub ALU,

---
 rtl/eater_cpu.sv | 206 ++++++++++++++++++++
 tb/tb_eater_cpu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/eater_cpu.sv
// -----------------------------------------------------------------------------
// eater_cpu -- 8-bit SAP-1-class CPU with a 16x8 RAM, 4-bit PC/MAR, A/B
// registers, add/sub ALU, instruction and output registers, carry/zero flags
// and a five-step microcoded control unit. Every internal register and the
// shared bus are exposed as observation outputs.
//
// Ports
//   clk               in   1   clock, all state updates on the rising edge
//   clr               in   1   synchronous active-high reset
//   bus               out  8   shared-bus value
//   mem_address_data  out  4   MAR contents
//   mem_data          out  8   RAM[MAR], combinational read
//   a_data            out  8   A register
//   b_data            out  8   B register
//   alu_data          out  8   ALU result (A+B, or A-B while SU is active)
//   instruction_data  out  8   instruction register {opcode, operand}
//   display_data      out  8   output (display) register
//   ctrl_state        out 16   current control word
//   ovf               out  1   latched carry flag
//   zf                out  1   latched zero flag
//
// Configuration macro
//   EARLY_STEP_RESET_EN  when defined, a step >= 2 whose control word is empty
//                        returns the step counter to 0 instead of advancing.
// -----------------------------------------------------------------------------
module eater_cpu (
    input  logic        clk,
    input  logic        clr,
    output logic [7:0]  bus,
    output logic [3:0]  mem_address_data,
    output logic [7:0]  mem_data,
    output logic [7:0]  a_data,
    output logic [7:0]  b_data,
    output logic [7:0]  alu_data,
    output logic [7:0]  instruction_data,
    output logic [7:0]  display_data,
    output logic [15:0] ctrl_state,
    output logic        ovf,
    output logic        zf
);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
        OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
        OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    // Control-word bit positions.
    localparam int C_HLT = 15, C_MI = 14, C_RI = 13, C_RO = 12;
    localparam int C_IO  = 11, C_II = 10, C_AI = 9,  C_AO = 8;
    localparam int C_EO  = 7,  C_SU = 6,  C_BI = 5,  C_OI = 4;
    localparam int C_CE  = 3,  C_CO = 2,  C_J  = 1,  C_FI = 0;

    localparam logic [7:0] DEFAULT_PROG [16] = '{
        8'h1E, 8'h2F, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1C, 8'h0E
    };

    // Declaration initialisers give power-up values equal to reset values.
    logic [7:0] ram_q [16] = DEFAULT_PROG;
    logic [3:0] pc_q   = '0;
    logic [3:0] mar_q  = '0;
    logic [7:0] a_q    = '0;
    logic [7:0] b_q    = '0;
    logic [7:0] ir_q   = '0;
    logic [7:0] out_q  = '0;
    logic       ovf_q  = 1'b0;
    logic       zf_q   = 1'b0;
    logic       halt_q = 1'b0;
    step_e      step_q = T0;
    step_e      step_d;

    logic [15:0] ctrl;
    logic [7:0]  bus_w;
    logic [8:0]  alu_sum;

    // ALU: subtraction is A + ~B + 1, so carry-out = 1 means "no borrow".
    assign alu_sum = {1'b0, a_q} + {1'b0, (ctrl[C_SU] ? ~b_q : b_q)} + {8'h00, ctrl[C_SU]};

    // Microcode decoder.
    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ctrl = '0;
        if (halt_q) begin
            ctrl[C_HLT] = 1'b1;
        end else begin
            case (step_q)
                T0: begin
                    ctrl[C_CO] = 1'b1;
                    ctrl[C_MI] = 1'b1;
                end
                T1: begin
                    ctrl[C_RO] = 1'b1;
                    ctrl[C_II] = 1'b1;
                    ctrl[C_CE] = 1'b1;
                end
                default: begin
                    case (ir_q[7:4])
                        OP_LDA: begin
                            if (step_q == T2) begin ctrl[C_IO] = 1'b1; ctrl[C_MI] = 1'b1; end
                            if (step_q == T3) begin ctrl[C_RO] = 1'b1; ctrl[C_AI] = 1'b1; end
                        end
                        OP_ADD, OP_SUB: begin
                            if (step_q == T2) begin ctrl[C_IO] = 1'b1; ctrl[C_MI] = 1'b1; end
                            if (step_q == T3) begin ctrl[C_RO] = 1'b1; ctrl[C_BI] = 1'b1; end
                            if (step_q == T4) begin
                                ctrl[C_EO] = 1'b1;
                                ctrl[C_AI] = 1'b1;
                                ctrl[C_FI] = 1'b1;
                                ctrl[C_SU] = (ir_q[7:4] == OP_SUB);
                            end
                        end
                        OP_STA: begin
                            if (step_q == T2) begin ctrl[C_IO] = 1'b1; ctrl[C_MI] = 1'b1; end
                            if (step_q == T3) begin ctrl[C_AO] = 1'b1; ctrl[C_RI] = 1'b1; end
                        end
                        OP_LDI: if (step_q == T2) begin ctrl[C_IO] = 1'b1; ctrl[C_AI] = 1'b1; end
                        OP_JMP: if (step_q == T2) begin ctrl[C_IO] = 1'b1; ctrl[C_J] = 1'b1; end
                        OP_JC:  if (step_q == T2 && ovf_q) begin ctrl[C_IO] = 1'b1; ctrl[C_J] = 1'b1; end
                        OP_JZ:  if (step_q == T2 && zf_q) begin ctrl[C_IO] = 1'b1; ctrl[C_J] = 1'b1; end
                        OP_OUT: if (step_q == T2) begin ctrl[C_AO] = 1'b1; ctrl[C_OI] = 1'b1; end
                        OP_HLT: if (step_q == T2) ctrl[C_HLT] = 1'b1;
                        default: ;
                    endcase
                end
            endcase
        end
    end

    // Shared bus; the microcode never enables two drivers in one step.
    always_comb begin
        bus_w = 8'h00;
        if (ctrl[C_CO])      bus_w = {4'h0, pc_q};
        else if (ctrl[C_RO]) bus_w = ram_q[mar_q];
        else if (ctrl[C_IO]) bus_w = {4'h0, ir_q[3:0]};
        else if (ctrl[C_AO]) bus_w = a_q;
        else if (ctrl[C_EO]) bus_w = alu_sum[7:0];
    end

    always_comb begin
        step_d = (step_q == T4) ? T0 : step_e'(step_q + 3'd1);
`ifdef EARLY_STEP_RESET_EN
        if (step_q >= T2 && ctrl == '0) step_d = T0;
`else
`endif
    end

    // Step counter and halt latch.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            step_q <= T0;
            halt_q <= 1'b0;
        end else if (!halt_q) begin
            step_q <= step_d;
            if (ctrl[C_HLT]) halt_q <= 1'b1;
        end
    end

    // Datapath registers; a halted machine only ever presents HLT, so nothing loads.
    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q  <= '0;
            mar_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ir_q  <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
            zf_q  <= 1'b0;
        end else begin
            if (ctrl[C_MI]) mar_q <= bus_w[3:0];
            if (ctrl[C_II]) ir_q  <= bus_w;
            if (ctrl[C_AI]) a_q   <= bus_w;
            if (ctrl[C_BI]) b_q   <= bus_w;
            if (ctrl[C_OI]) out_q <= bus_w;
            if (ctrl[C_J])       pc_q <= bus_w[3:0];
            else if (ctrl[C_CE]) pc_q <= pc_q + 4'd1;
            if (ctrl[C_FI]) begin
                ovf_q <= alu_sum[8];
                zf_q  <= (alu_sum[7:0] == 8'h00);
            end
        end
    end

    // NOTE: the RAM is deliberately reset -- clr reloads the boot program into every word.
    always_ff @(posedge clk) begin
        if (clr)             ram_q <= DEFAULT_PROG;
        else if (ctrl[C_RI]) ram_q[mar_q] <= bus_w;
    end

    assign bus              = bus_w;
    assign mem_address_data = mar_q;
    assign mem_data         = ram_q[mar_q];
    assign a_data           = a_q;
    assign b_data           = b_q;
    assign alu_data         = alu_sum[7:0];
    assign instruction_data = ir_q;
    assign display_data     = out_q;
    assign ctrl_state       = ctrl;
    assign ovf              = ovf_q;
    assign zf               = zf_q;

endmodule

// File: tb/tb_eater_cpu.sv
// -----------------------------------------------------------------------------
// tb_eater_cpu -- self-checking bench for eater_cpu. A table of expected
// observations per program is pushed into a scoreboard queue after reset; a
// negedge monitor pops each entry when the post-reset edge count reaches it.
// Reset state and clr-during-instruction are checked by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_eater_cpu;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [7:0]  bus, mem_data, a_data, b_data, alu_data, instruction_data, display_data;
    logic [3:0]  mem_address_data;
    logic [15:0] ctrl_state;
    logic        ovf, zf;

    eater_cpu dut (
        .clk(clk), .clr(clr), .bus(bus), .mem_address_data(mem_address_data),
        .mem_data(mem_data), .a_data(a_data), .b_data(b_data), .alu_data(alu_data),
        .instruction_data(instruction_data), .display_data(display_data),
        .ctrl_state(ctrl_state), .ovf(ovf), .zf(zf)
    );

    always #5 clk = ~clk;

    typedef enum {S_BUS, S_MAR, S_MEM, S_A, S_B, S_ALU, S_IR, S_DISP, S_CTRL, S_OVF, S_ZF, S_PC} sig_e;

    typedef struct {
        int          prog;
        int          edge_n;
        sig_e        sig;
        logic [15:0] val;
        string       name;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    vec_t mon_e;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    logic [7:0] prog_sub [16];
    logic [7:0] prog_add [16];

    // Posedges since the last reset edge.
    always @(posedge clk) edge_cnt <= clr ? 0 : edge_cnt + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [15:0] sample(input sig_e s);
        case (s)
            S_BUS:  return {8'h00, bus};
            S_MAR:  return {12'h000, mem_address_data};
            S_MEM:  return {8'h00, mem_data};
            S_A:    return {8'h00, a_data};
            S_B:    return {8'h00, b_data};
            S_ALU:  return {8'h00, alu_data};
            S_IR:   return {8'h00, instruction_data};
            S_DISP: return {8'h00, display_data};
            S_CTRL: return ctrl_state;
            S_OVF:  return {15'h0000, ovf};
            S_ZF:   return {15'h0000, zf};
            S_PC:   return {12'h000, dut.pc_q};
            default: return 16'hDEAD;
        endcase
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].edge_n == edge_cnt) begin
            mon_e = sb_q.pop_front();
            check(mon_e.name, sample(mon_e.sig), mon_e.val);
        end
    end

    task automatic add(input int p, input int e, input sig_e s, input logic [15:0] v, input string n);
        vec_t t;
        t.prog = p; t.edge_n = e; t.sig = s; t.val = v; t.name = n;
        vecs.push_back(t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
    endtask

    task automatic run_prog(input int p);
        for (int i = 0; i < vecs.size(); i++)
            if (vecs[i].prog == p) sb_q.push_back(vecs[i]);
        for (int i = 0; i < 80 && sb_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL prog%0d_timeout: %0d entries left, expected 0", p, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        // Program 0: default boot program (LDA 14, ADD 15, OUT, HLT).
        add(0, 1,  S_CTRL, 16'h1408, "p0_t1_ctrl");
        add(0, 1,  S_BUS,  16'h001E, "p0_t1_bus");
        add(0, 2,  S_IR,   16'h001E, "p0_ir_lda");
        add(0, 2,  S_CTRL, 16'h4800, "p0_lda_t2_ctrl");
        add(0, 2,  S_BUS,  16'h000E, "p0_lda_t2_bus");
        add(0, 3,  S_MAR,  16'h000E, "p0_mar");
        add(0, 3,  S_MEM,  16'h001C, "p0_mem");
        add(0, 3,  S_CTRL, 16'h1200, "p0_lda_t3_ctrl");
        add(0, 4,  S_A,    16'h001C, "p0_a_lda");
        add(0, 9,  S_B,    16'h000E, "p0_b");
        add(0, 9,  S_ALU,  16'h002A, "p0_alu");
        add(0, 9,  S_CTRL, 16'h0281, "p0_add_t4_ctrl");
        add(0, 10, S_A,    16'h002A, "p0_a_add");
        add(0, 10, S_OVF,  16'h0000, "p0_ovf");
        add(0, 10, S_ZF,   16'h0000, "p0_zf");
        add(0, 12, S_IR,   16'h00E0, "p0_ir_out");
        add(0, 12, S_CTRL, 16'h0110, "p0_out_ctrl");
        add(0, 12, S_DISP, 16'h0000, "p0_disp_pre");
        add(0, 13, S_DISP, 16'h002A, "p0_disp");
        add(0, 17, S_CTRL, 16'h8000, "p0_hlt_t2_ctrl");
        add(0, 17, S_PC,   16'h0004, "p0_pc_hlt");
        add(0, 18, S_CTRL, 16'h8000, "p0_halted_ctrl");
        add(0, 18, S_DISP, 16'h002A, "p0_halted_disp");
        add(0, 30, S_CTRL, 16'h8000, "p0_frozen_ctrl");
        add(0, 30, S_DISP, 16'h002A, "p0_frozen_disp");
        add(0, 30, S_PC,   16'h0004, "p0_frozen_pc");
        add(0, 30, S_A,    16'h002A, "p0_frozen_a");
        add(0, 30, S_BUS,  16'h0000, "p0_frozen_bus");
        // Program 1: LDI 15, SUB 15, JZ 5 (taken), ..., 5: LDI 7, OUT, HLT.
        add(1, 3,  S_A,    16'h000F, "p1_a_ldi");
        add(1, 9,  S_CTRL, 16'h02C1, "p1_sub_t4_ctrl");
        add(1, 9,  S_ALU,  16'h0000, "p1_alu_sub");
        add(1, 9,  S_B,    16'h000F, "p1_b");
        add(1, 10, S_A,    16'h0000, "p1_a_sub");
        add(1, 10, S_ZF,   16'h0001, "p1_zf");
        add(1, 10, S_OVF,  16'h0001, "p1_ovf");
        add(1, 12, S_CTRL, 16'h0802, "p1_jz_ctrl");
        add(1, 12, S_BUS,  16'h0005, "p1_jz_bus");
        add(1, 13, S_PC,   16'h0005, "p1_pc_jz");
        add(1, 18, S_A,    16'h0007, "p1_a_ldi7");
        add(1, 23, S_DISP, 16'h0007, "p1_disp");
        add(1, 29, S_CTRL, 16'h8000, "p1_halted");
        add(1, 29, S_PC,   16'h0008, "p1_pc_end");
        add(1, 29, S_ZF,   16'h0001, "p1_zf_kept");
        // Program 2: LDA 14 (F0), ADD 15 (20) overflows, STA 13, JC 6 (taken), 6: OUT, HLT.
        add(2, 4,  S_A,    16'h00F0, "p2_a_lda");
        add(2, 9,  S_B,    16'h0020, "p2_b");
        add(2, 9,  S_ALU,  16'h0010, "p2_alu");
        add(2, 10, S_A,    16'h0010, "p2_a_add");
        add(2, 10, S_OVF,  16'h0001, "p2_ovf");
        add(2, 10, S_ZF,   16'h0000, "p2_zf");
        add(2, 13, S_CTRL, 16'h2100, "p2_sta_ctrl");
        add(2, 13, S_BUS,  16'h0010, "p2_sta_bus");
        add(2, 13, S_MEM,  16'h0000, "p2_ram13_pre");
        add(2, 14, S_MEM,  16'h0010, "p2_ram13");
        add(2, 17, S_CTRL, 16'h0802, "p2_jc_ctrl");
        add(2, 18, S_PC,   16'h0006, "p2_pc_jc");
        add(2, 23, S_DISP, 16'h0010, "p2_disp");
        add(2, 29, S_CTRL, 16'h8000, "p2_halted");
        add(2, 29, S_PC,   16'h0008, "p2_pc_end");

        prog_sub = '{8'h5F, 8'h3F, 8'h85, 8'hF0, 8'hF0, 8'h57, 8'hE0, 8'hF0,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F};
        prog_add = '{8'h1E, 8'h2F, 8'h4D, 8'h76, 8'hF0, 8'hF0, 8'hE0, 8'hF0,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h20};

        // Reset state, then the default program.
        do_reset();
        check("rst_bus",  {8'h00, bus}, 16'h0000);
        check("rst_mar",  {12'h000, mem_address_data}, 16'h0000);
        check("rst_mem",  {8'h00, mem_data}, 16'h001E);
        check("rst_a",    {8'h00, a_data}, 16'h0000);
        check("rst_b",    {8'h00, b_data}, 16'h0000);
        check("rst_alu",  {8'h00, alu_data}, 16'h0000);
        check("rst_ir",   {8'h00, instruction_data}, 16'h0000);
        check("rst_disp", {8'h00, display_data}, 16'h0000);
        check("rst_ctrl", ctrl_state, 16'h4004);
        check("rst_ovf",  {15'h0000, ovf}, 16'h0000);
        check("rst_zf",   {15'h0000, zf}, 16'h0000);
        run_prog(0);

        // Preloaded programs, written into RAM right after the reset edge.
        do_reset();
        for (int i = 0; i < 16; i++) dut.ram_q[i] = prog_sub[i];
        run_prog(1);

        do_reset();
        for (int i = 0; i < 16; i++) dut.ram_q[i] = prog_add[i];
        run_prog(2);

        // clr asserted while LDA sits in T3: reset wins over RO|AI.
        do_reset();
        repeat (3) @(negedge clk);
        #1;
        check("clr_mid_pre_ctrl", ctrl_state, 16'h1200);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("clr_mid_pc",   {12'h000, dut.pc_q}, 16'h0000);
        check("clr_mid_step", {13'h0000, dut.step_q}, 16'h0000);
        check("clr_mid_a",    {8'h00, a_data}, 16'h0000);
        check("clr_mid_ctrl", ctrl_state, 16'h4004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
